// File: rtl/led_chain_pkg.sv
// LED chain driver shared state codes and sizing helpers.
// Widths are derived from parameters through the functions below.
package led_chain_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_LATCH = 3'd5;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int xfer_len(
    input int n_ch,
    input int ch_w,
    input int div,
    input int lat
  );
    return n_ch * (2 + 2 * div * ch_w) + div + lat;
  endfunction

  localparam int DEF_FRAME_PERIOD = 16666;
  localparam int DEF_FRAME_MAX    = 120;
  localparam int DEF_N_CHANNELS   = 12;
  localparam int AW    = clog2_min1(DEF_N_CHANNELS);
  localparam int FW    = clog2_min1(DEF_FRAME_MAX + 1);
  localparam int CNT_W = clog2_min1(DEF_FRAME_PERIOD + 1);

endpackage

// File: rtl/led_chain_driver_frame_timer.sv
// Free-running frame period counter with registered tick
// and wrapping frame index.
module frame_timer
  import led_chain_pkg::*;
#(
  parameter int FRAME_PERIOD = 16666,
  parameter int FRAME_MAX    = 120,
  localparam int CW = clog2_min1(FRAME_PERIOD + 1),
  localparam int FW_L = clog2_min1(FRAME_MAX + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic [FW_L-1:0] o_frame,
  output logic            o_frame_tick
);

  localparam logic [CW-1:0]   P_END = CW'(FRAME_PERIOD);
  localparam logic [CW-1:0]   C_ONE = CW'(1);
  localparam logic [FW_L-1:0] F_END = FW_L'(FRAME_MAX);
  localparam logic [FW_L-1:0] F_ONE = FW_L'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt          <= '0;
      o_frame      <= '0;
      o_frame_tick <= 1'b0;
    end else begin
      o_frame_tick <= (cnt == P_END);
      if (cnt == P_END) begin
        cnt     <= '0;
        o_frame <= (o_frame == F_END) ? '0 : o_frame + F_ONE;
      end else begin
        cnt <= cnt + C_ONE;
      end
    end
  end

endmodule

// File: rtl/led_chain_driver.sv
// Frame-paced serializer: streams store words MSB-first onto the
// o_clk/o_dai chain each frame tick, then strobes o_lat.
module led_chain_driver
  import led_chain_pkg::*;
#(
  parameter int FRAME_PERIOD = 16666,
  parameter int FRAME_MAX    = 120,
  parameter int N_CHANNELS   = 12,
  parameter int CH_WIDTH     = 16,
  parameter int CLK_DIV      = 2,
  parameter int LAT_CYCLES   = 4,
  parameter bit XFER_CHECK   = 1'b1,
  localparam int AW_L = clog2_min1(N_CHANNELS),
  localparam int FW_L = clog2_min1(FRAME_MAX + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  output logic [AW_L-1:0]     o_rd_addr,
  input  logic [CH_WIDTH-1:0] i_rd_data,
  output logic [FW_L-1:0]     o_frame,
  output logic                o_frame_tick,
  output logic                o_busy,
  output logic                o_overrun,
  output logic                o_clk,
  output logic                o_dai,
  output logic                o_lat
);

  localparam int XFER_T = xfer_len(N_CHANNELS, CH_WIDTH, CLK_DIV, LAT_CYCLES);
  localparam int BW = clog2_min1(CH_WIDTH);
  localparam int DW = clog2_min1(2 * CLK_DIV);
  localparam int LW = clog2_min1(LAT_CYCLES);

  localparam logic [AW_L-1:0] CH_LAST = AW_L'(N_CHANNELS - 1);
  localparam logic [AW_L-1:0] CH_ONE  = AW_L'(1);
  localparam logic [BW-1:0]   B_MAX   = BW'(CH_WIDTH - 1);
  localparam logic [BW-1:0]   B_ONE   = BW'(1);
  localparam logic [DW-1:0]   D_HI    = DW'(CLK_DIV);
  localparam logic [DW-1:0]   D_END   = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0]   G_END   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]   D_ONE   = DW'(1);
  localparam logic [LW-1:0]   L_END   = LW'(LAT_CYCLES - 1);
  localparam logic [LW-1:0]   L_ONE   = LW'(1);

  if (XFER_CHECK && XFER_T >= FRAME_PERIOD + 1) begin : g_xfer_chk
    $fatal(1, "led_chain_driver: transfer longer than frame period");
  end

  logic [2:0]          state;
  logic [AW_L-1:0]     ch;
  logic [CH_WIDTH-1:0] sr;
  logic [BW-1:0]       bitc;
  logic [DW-1:0]       dcnt;
  logic [LW-1:0]       lcnt;

  frame_timer #(
    .FRAME_PERIOD(FRAME_PERIOD),
    .FRAME_MAX   (FRAME_MAX)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_frame     (o_frame),
    .o_frame_tick(o_frame_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      ch    <= '0;
      sr    <= '0;
      bitc  <= '0;
      dcnt  <= '0;
      lcnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (o_frame_tick && i_enable) begin
            ch    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          sr    <= i_rd_data;
          bitc  <= B_MAX;
          dcnt  <= '0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          // Low half then high half; advance after the high half.
          if (dcnt == D_END) begin
            dcnt <= '0;
            sr   <= sr << 1;
            if (bitc == '0) begin
              if (ch == CH_LAST) begin
                state <= S_GAP;
              end else begin
                ch    <= ch + CH_ONE;
                state <= S_FETCH;
              end
            end else begin
              bitc <= bitc - B_ONE;
            end
          end else begin
            dcnt <= dcnt + D_ONE;
          end
        end
        S_GAP: begin
          if (dcnt == G_END) begin
            dcnt  <= '0;
            lcnt  <= '0;
            state <= S_LATCH;
          end else begin
            dcnt <= dcnt + D_ONE;
          end
        end
        S_LATCH: begin
          if (lcnt == L_END) begin
            state <= S_IDLE;
          end else begin
            lcnt <= lcnt + L_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_addr = ch;
  assign o_busy    = (state != S_IDLE);
  assign o_overrun = o_frame_tick & o_busy;
  assign o_clk     = (state == S_SHIFT) && (dcnt >= D_HI);
  assign o_dai     = (state == S_SHIFT) && sr[CH_WIDTH-1];
  assign o_lat     = (state == S_LATCH);

endmodule

// File: tb/tb_led_chain_driver.sv
// Bench for led_chain_driver: three configurations, randomized store
// contents, expectations derived from frame/transfer arithmetic.
module tb_led_chain_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int sel    = 0;

  // A: FP=99 FMAX=3 N=2 W=8 DIV=1 LAT=4
  logic       rst_a = 1'b1, en_a = 1'b0;
  logic [0:0] addr_a;
  logic [7:0] rd_a;
  logic [1:0] fr_a;
  logic       tk_a, bz_a, ov_a, ck_a, da_a, lt_a;
  logic [7:0] mem_a [2];
  always @(posedge clk) rd_a <= mem_a[addr_a];

  // O: FP=30 same serial config, length check off
  logic       rst_o = 1'b1, en_o = 1'b0;
  logic [0:0] addr_o;
  logic [7:0] rd_o;
  logic [6:0] fr_o;
  logic       tk_o, bz_o, ov_o, ck_o, da_o, lt_o;
  logic [7:0] mem_o [2];
  always @(posedge clk) rd_o <= mem_o[addr_o];

  // D: all defaults
  logic        rst_d = 1'b1, en_d = 1'b0;
  logic [3:0]  addr_d;
  logic [15:0] rd_d;
  logic [6:0]  fr_d;
  logic        tk_d, bz_d, ov_d, ck_d, da_d, lt_d;
  logic [15:0] mem_d [16];
  always @(posedge clk) rd_d <= mem_d[addr_d];

  led_chain_driver #(
    .FRAME_PERIOD(99), .FRAME_MAX(3), .N_CHANNELS(2),
    .CH_WIDTH(8), .CLK_DIV(1), .LAT_CYCLES(4)
  ) u_a (
    .i_clk(clk), .i_rst(rst_a), .i_enable(en_a),
    .o_rd_addr(addr_a), .i_rd_data(rd_a), .o_frame(fr_a),
    .o_frame_tick(tk_a), .o_busy(bz_a), .o_overrun(ov_a),
    .o_clk(ck_a), .o_dai(da_a), .o_lat(lt_a)
  );

  led_chain_driver #(
    .FRAME_PERIOD(30), .N_CHANNELS(2), .CH_WIDTH(8),
    .CLK_DIV(1), .LAT_CYCLES(4), .XFER_CHECK(1'b0)
  ) u_o (
    .i_clk(clk), .i_rst(rst_o), .i_enable(en_o),
    .o_rd_addr(addr_o), .i_rd_data(rd_o), .o_frame(fr_o),
    .o_frame_tick(tk_o), .o_busy(bz_o), .o_overrun(ov_o),
    .o_clk(ck_o), .o_dai(da_o), .o_lat(lt_o)
  );

  led_chain_driver u_d (
    .i_clk(clk), .i_rst(rst_d), .i_enable(en_d),
    .o_rd_addr(addr_d), .i_rd_data(rd_d), .o_frame(fr_d),
    .o_frame_tick(tk_d), .o_busy(bz_d), .o_overrun(ov_d),
    .o_clk(ck_d), .o_dai(da_d), .o_lat(lt_d)
  );

  logic [7:0] p_frame;
  logic [3:0] p_addr;
  logic       p_tick, p_busy, p_ovr, p_clk, p_dai, p_lat;

  always_comb begin
    p_frame = '0;
    p_addr  = '0;
    {p_tick, p_busy, p_ovr, p_clk, p_dai, p_lat} = '0;
    case (sel)
      0: begin
        p_frame = 8'(fr_a); p_addr = 4'(addr_a);
        {p_tick, p_busy, p_ovr, p_clk, p_dai, p_lat} =
          {tk_a, bz_a, ov_a, ck_a, da_a, lt_a};
      end
      1: begin
        p_frame = 8'(fr_o); p_addr = 4'(addr_o);
        {p_tick, p_busy, p_ovr, p_clk, p_dai, p_lat} =
          {tk_o, bz_o, ov_o, ck_o, da_o, lt_o};
      end
      default: begin
        p_frame = 8'(fr_d); p_addr = 4'(addr_d);
        {p_tick, p_busy, p_ovr, p_clk, p_dai, p_lat} =
          {tk_d, bz_d, ov_d, ck_d, da_d, lt_d};
      end
    endcase
  end

  int   ticks[$], frames[$], ovrs[$], addrs[$];
  bit   bits[$];
  int   busy_cnt, busy_first, n_xfer, clk_hi, lat_cnt, lat_first, last_fall;
  logic [17:0] snap;

  function automatic int model_t(input int n, input int w, input int div, input int lat);
    return n * (2 + 2 * div * w) + div + lat;
  endfunction

  task automatic set_rst(input int s, input logic v);
    case (s)
      0: rst_a = v;
      1: rst_o = v;
      default: rst_d = v;
    endcase
  endtask

  task automatic set_en(input int s, input logic v);
    case (s)
      0: en_a = v;
      1: en_o = v;
      default: en_d = v;
    endcase
  endtask

  task automatic do_reset(input int s);
    @(negedge clk);
    set_rst(s, 1'b1);
    repeat (2) @(negedge clk);
    set_rst(s, 1'b0);
  endtask

  // Sample at negedges; cycle 0 is the current (first post-reset) cycle.
  task automatic capture(input int n, input int drop_at, input int rst_at, input int snap_at);
    logic pc, pb, pl;
    pc = 1'b0; pb = 1'b0; pl = 1'b0;
    ticks.delete(); frames.delete(); ovrs.delete(); addrs.delete(); bits.delete();
    busy_cnt = 0; busy_first = -1; n_xfer = 0; clk_hi = 0;
    lat_cnt = 0; lat_first = -1; last_fall = -1; snap = '1;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      if (p_tick) begin ticks.push_back(c); frames.push_back(int'(p_frame)); end
      if (p_ovr) ovrs.push_back(c);
      if (p_busy) begin
        busy_cnt++;
        addrs.push_back(int'(p_addr));
        if (!pb) begin n_xfer++; if (busy_first < 0) busy_first = c; end
      end
      if (p_clk) clk_hi++;
      if (p_clk && !pc) bits.push_back(p_dai);
      if (!p_clk && pc) last_fall = c;
      if (p_lat) begin lat_cnt++; if (!pl) lat_first = c; end
      if (c == snap_at)
        snap = {p_frame, p_addr, p_tick, p_busy, p_ovr, p_clk, p_dai, p_lat};
      pc = p_clk; pb = p_busy; pl = p_lat;
      if (c == drop_at) set_en(sel, 1'b0);
      if (rst_at >= 0 && c == rst_at) set_rst(sel, 1'b1);
      if (rst_at >= 0 && c == rst_at + 1) set_rst(sel, 1'b0);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({fr_a, addr_a, tk_a, bz_a, ov_a, ck_a, da_a, lt_a} !== '0)
      $display("FAIL reset_a: got %b want 0", {fr_a, addr_a, tk_a, bz_a, ov_a, ck_a, da_a, lt_a});
    else n_pass++;
    n_chk++;
    if ({fr_o, addr_o, tk_o, bz_o, ov_o, ck_o, da_o, lt_o} !== '0)
      $display("FAIL reset_o: got %b want 0", {fr_o, addr_o, tk_o, bz_o, ov_o, ck_o, da_o, lt_o});
    else n_pass++;
    n_chk++;
    if ({fr_d, addr_d, tk_d, bz_d, ov_d, ck_d, da_d, lt_d} !== '0)
      $display("FAIL reset_d: got %b want 0", {fr_d, addr_d, tk_d, bz_d, ov_d, ck_d, da_d, lt_d});
    else n_pass++;
  endtask

  task automatic test_tick_wrap();
    int gc, gf;
    sel = 0; en_a = 1'b0;
    mem_a[0] = 8'($urandom); mem_a[1] = 8'($urandom);
    do_reset(0);
    capture(520, -1, -1, -1);
    n_chk++;
    if (ticks.size() !== 5) $display("FAIL tick_count: got %0d want 5", ticks.size());
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      gc = (k - 1 < ticks.size()) ? ticks[k-1] : -1;
      gf = (k - 1 < frames.size()) ? frames[k-1] : -1;
      n_chk++;
      if (gc !== k * 100 || gf !== k % 4)
        $display("FAIL tick_%0d: got cycle %0d frame %0d want cycle %0d frame %0d",
                 k, gc, gf, k * 100, k % 4);
      else n_pass++;
    end
    n_chk++;
    if (clk_hi !== 0 || busy_cnt !== 0 || ovrs.size() !== 0)
      $display("FAIL idle_quiet: got clk_hi %0d busy %0d ovr %0d want 0 0 0",
               clk_hi, busy_cnt, ovrs.size());
    else n_pass++;
  endtask

  task automatic check_serial_frame(input string tag, input logic [15:0] want_w);
    logic [15:0] got_w;
    got_w = '0;
    foreach (bits[i]) got_w = {got_w[14:0], bits[i]};
    n_chk++;
    if (bits.size() !== 16 || got_w !== want_w)
      $display("FAIL %s_bits: got %0d bits %h want 16 bits %h", tag, bits.size(), got_w, want_w);
    else n_pass++;
    n_chk++;
    if (lat_cnt !== 4 || lat_first - last_fall !== 1)
      $display("FAIL %s_latch: got len %0d offset %0d want len 4 offset 1",
               tag, lat_cnt, lat_first - last_fall);
    else n_pass++;
  endtask

  task automatic test_serial();
    int t;
    t = model_t(2, 8, 1, 4);
    for (int r = 0; r < 4; r++) begin
      sel = 0; en_a = 1'b1;
      if (r == 0) begin mem_a[0] = 8'hA5; mem_a[1] = 8'h3C; end
      else begin mem_a[0] = 8'($urandom); mem_a[1] = 8'($urandom); end
      do_reset(0);
      capture(150, -1, -1, -1);
      check_serial_frame("serial", {mem_a[0], mem_a[1]});
      n_chk++;
      if (busy_cnt !== t || busy_first !== 101)
        $display("FAIL serial_busy: got %0d from %0d want %0d from 101", busy_cnt, busy_first, t);
      else n_pass++;
      n_chk++;
      if (addrs.size() < 19 || addrs[0] !== 0 || addrs[18] !== 1)
        $display("FAIL serial_addr: got %0d,%0d want 0,1",
                 addrs.size() > 0 ? addrs[0] : -1, addrs.size() > 18 ? addrs[18] : -1);
      else n_pass++;
    end
  endtask

  task automatic test_defaults();
    int t, ones;
    t = model_t(12, 16, 2, 4);
    sel = 2; en_d = 1'b1;
    for (int i = 0; i < 16; i++) mem_d[i] = 16'hFFFF;
    do_reset(2);
    capture(16667 + t + 10, -1, -1, -1);
    ones = 0;
    foreach (bits[i]) if (bits[i]) ones++;
    n_chk++;
    if (busy_cnt !== t || busy_first !== 16668)
      $display("FAIL dflt_busy: got %0d from %0d want %0d from 16668", busy_cnt, busy_first, t);
    else n_pass++;
    n_chk++;
    if (bits.size() !== 192 || ones !== 192)
      $display("FAIL dflt_bits: got %0d edges %0d ones want 192 192", bits.size(), ones);
    else n_pass++;
    n_chk++;
    if (ticks.size() !== 1 || frames.size() !== 1 || frames[0] !== 1)
      $display("FAIL dflt_tick: got %0d ticks want 1 tick with frame 1", ticks.size());
    else n_pass++;
  endtask

  task automatic test_overrun();
    int t, end_c, exp_busy, exp_x, n;
    int exp_ovr[$];
    t = model_t(2, 8, 1, 4);
    n = 140; end_c = -1; exp_busy = 0; exp_x = 0;
    for (int c = 31; c < n; c += 31) begin
      if (c <= end_c) exp_ovr.push_back(c);
      else begin
        exp_x++;
        end_c = c + t;
        exp_busy += ((end_c < n) ? end_c : n - 1) - c;
      end
    end
    sel = 1; en_o = 1'b1;
    mem_o[0] = 8'($urandom); mem_o[1] = 8'($urandom);
    do_reset(1);
    capture(n, -1, -1, -1);
    n_chk++;
    if (ovrs.size() !== exp_ovr.size())
      $display("FAIL ovr_count: got %0d want %0d", ovrs.size(), exp_ovr.size());
    else n_pass++;
    foreach (exp_ovr[i]) begin
      n_chk++;
      if (i >= ovrs.size() || ovrs[i] !== exp_ovr[i])
        $display("FAIL ovr_cycle[%0d]: got %0d want %0d", i,
                 i < ovrs.size() ? ovrs[i] : -1, exp_ovr[i]);
      else n_pass++;
    end
    n_chk++;
    if (n_xfer !== exp_x || busy_cnt !== exp_busy)
      $display("FAIL ovr_xfer: got %0d xfers %0d busy want %0d %0d",
               n_xfer, busy_cnt, exp_x, exp_busy);
    else n_pass++;
    foreach (frames[i]) begin
      n_chk++;
      if (frames[i] !== i + 1)
        $display("FAIL ovr_frame[%0d]: got %0d want %0d", i, frames[i], i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_enable_drop();
    sel = 0; en_a = 1'b1;
    mem_a[0] = 8'($urandom); mem_a[1] = 8'($urandom);
    do_reset(0);
    capture(215, 108, -1, -1);
    check_serial_frame("endrop", {mem_a[0], mem_a[1]});
    n_chk++;
    if (n_xfer !== 1 || busy_cnt !== model_t(2, 8, 1, 4) || ovrs.size() !== 0 || ticks.size() !== 2)
      $display("FAIL endrop_xfer: got %0d xfers %0d busy %0d ovr %0d ticks want 1 41 0 2",
               n_xfer, busy_cnt, ovrs.size(), ticks.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    sel = 0; en_a = 1'b1;
    mem_a[0] = 8'($urandom); mem_a[1] = 8'($urandom);
    do_reset(0);
    capture(212, -1, 109, 110);
    n_chk++;
    if (snap !== '0) $display("FAIL rstmid_outputs: got %b want 0", snap);
    else n_pass++;
    n_chk++;
    if (lat_cnt !== 0) $display("FAIL rstmid_latch: got %0d want 0", lat_cnt);
    else n_pass++;
    n_chk++;
    if (ticks.size() !== 2 || ticks[0] !== 100 || ticks[1] !== 210)
      $display("FAIL rstmid_tick: got %0d ticks last %0d want 2 ticks last 210",
               ticks.size(), ticks.size() > 0 ? ticks[ticks.size()-1] : -1);
    else n_pass++;
    n_chk++;
    if (n_xfer !== 2 || busy_cnt !== 10)
      $display("FAIL rstmid_busy: got %0d xfers %0d busy want 2 10", n_xfer, busy_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    rst_o = 1'b0;
    rst_d = 1'b0;
    test_tick_wrap();
    test_serial();
    test_overrun();
    test_enable_drop();
    test_reset_mid();
    test_defaults();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_chain_driver.md
Name: led_chain_driver

Overview:
- Parametrised successor to the single-purpose frame timer used for the lamp's LED driver chain.
- Generates the frame tick and a wrapping frame index.
- On each frame tick, fetches N_CHANNELS words from an external synchronous-read store and shifts them MSB-first onto the serial LED chain (o_clk / o_dai), then pulses o_lat.
- Sits between the pattern/frame-buffer logic and the board-level driver chain pins.

Parameters:
- FRAME_PERIOD, 16666: frame tick every FRAME_PERIOD+1 i_clk cycles.
- FRAME_MAX, 120: frame index counts 0..FRAME_MAX, then wraps.
- N_CHANNELS, 12: words shifted per frame (>=1).
- CH_WIDTH, 16: bits per word (>=1).
- CLK_DIV, 2: i_clk cycles per o_clk half-period (>=1).
- LAT_CYCLES, 4: o_lat high duration in i_clk cycles (>=1).

Ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  permits starting a transfer on a tick.
- o_rd_addr  out  AW=max(1,$clog2(N_CHANNELS))  word address to store.
- i_rd_data  in  CH_WIDTH  store data, valid 1 cycle after o_rd_addr.
- o_frame  out  FW=$clog2(FRAME_MAX+1)  current frame index.
- o_frame_tick  out  1  one-cycle frame strobe.
- o_busy  out  1  transfer in progress.
- o_overrun  out  1  one-cycle pulse: tick arrived while busy.
- o_clk  out  1  serial clock to chain.
- o_dai  out  1  serial data to chain.
- o_lat  out  1  latch strobe to chain.

Behaviour:
- Reset (i_rst high at a clock edge): all counters 0, FSM=IDLE, every output 0 the next cycle. Reset mid-transfer aborts the transfer immediately with no latch pulse.
- Frame timer: counter width $clog2(FRAME_PERIOD+1).
  - Counts 0..FRAME_PERIOD, then wraps to 0.
  - Runs unconditionally; it is not gated by i_enable or busy.
  - Cycle 0 is the first cycle after reset release. o_frame_tick (registered) is high in cycle FRAME_PERIOD+1, and every FRAME_PERIOD+1 cycles thereafter.
  - o_frame increments on the same edge that raises o_frame_tick, wrapping FRAME_MAX -> 0.
  - All compares use width-truncated parameter constants.
- FSM states: IDLE, FETCH, LOAD, SHIFT, GAP, LATCH.
  - IDLE: o_clk=o_dai=o_lat=0, o_busy=0. On o_frame_tick & i_enable -> FETCH with ch=0. A tick while i_enable=0 is ignored; no overrun.
  - FETCH (1 cycle): o_rd_addr=ch -> LOAD.
  - LOAD (1 cycle): shift reg <= i_rd_data, bit counter <= CH_WIDTH-1 -> SHIFT.
  - SHIFT: o_dai=sr[MSB] throughout the bit. o_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles, so data is stable at the rising edge. At the end of the high phase, shift left. After the last bit: if ch<N_CHANNELS-1, ch++ and -> FETCH; else -> GAP.
  - o_clk stays low during FETCH, LOAD, GAP, LATCH and IDLE.
  - GAP: CLK_DIV cycles with o_dai=0 -> LATCH.
  - LATCH: o_lat=1 for LAT_CYCLES cycles -> IDLE.
- o_busy: high in all states except IDLE.
- Transfer length: T = N_CHANNELS*(2+2*CLK_DIV*CH_WIDTH) + CLK_DIV + LAT_CYCLES cycles. With defaults T = 798.
- Overrun: a tick while o_busy=1 gives o_overrun=1 for that cycle. The transfer in progress continues unaffected, the tick is not queued, and the frame index still advances.
- i_enable falling mid-transfer: the transfer completes normally, including the latch.
- Elaboration-time check: T < FRAME_PERIOD+1 is required (fatal assertion in simulation).

Decomposition:
- Package led_chain_pkg: FSM state encoding; localparams AW, FW, count width; function computing T.
- Sub-module frame_timer: period counter, frame index, tick. Parameters FRAME_PERIOD and FRAME_MAX; ports i_clk, i_rst, o_frame, o_frame_tick.
- The serializer FSM lives in led_chain_driver.

Test Plan:
- Tick and frame wrap. FRAME_PERIOD=99, FRAME_MAX=3, i_enable=0 -> o_frame_tick high at cycles 100, 200, 300, 400, 500. o_frame sequence is 1, 2, 3, 0, 1. o_clk never toggles.
- Serialisation. N_CHANNELS=2, CH_WIDTH=8, CLK_DIV=1, store {0xA5, 0x3C}, i_enable=1 ->
  - o_rd_addr 0 then 1;
  - 16 o_clk rising edges, o_dai sampled = 1010_0101_0011_1100;
  - o_lat high 4 cycles starting 1 cycle after the last o_clk falling edge;
  - o_busy high exactly 41 cycles.
- Defaults. Constant store 0xFFFF -> o_busy high 798 cycles per frame; 192 o_clk rising edges per frame, all with o_dai=1.
- Overrun. FRAME_PERIOD=30 with the serialisation config (T=41), run at the elaboration check disabled -> o_overrun pulses on the tick arriving mid-transfer. No new transfer starts from that tick, and o_frame still increments.
- Enable drop. i_enable 1->0 midway through channel 0 -> the full 16 bits plus latch complete. The next tick produces no transfer and no overrun.
- Reset mid-SHIFT. Assert i_rst for 1 cycle -> next cycle all outputs 0, o_busy 0, no o_lat pulse. The first tick comes FRAME_PERIOD+1 cycles after release.
